sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter_pkg.sv | 26 ++
 rtl/sram_arbiter.sv | 140 ++++++++++++++
 tb/tb_sram_arbiter.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the single-port sram-like arbiter: FSM and owner
// encodings, op codes and the latched request payload.
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/sram_arbiter.sv
// Two-requester (inst/data) to one sram-like master arbiter, one transaction in
// flight. Optional inst starvation guard enabled by macro ARB_STARVE_GUARD_EN.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_p,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [31:0] m_addr,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata,
  output logic        busy,
  output state_e      state_dbg
);

  if (STARVE_LIMIT < 1) begin : g_limit_check
    $error("STARVE_LIMIT must be at least 1");
  end

  state_e    state_q, state_d;
  owner_e    owner_q, owner_d;
  sram_req_t pay_q, pay_d;
  logic      grant;
  logic      starve_hit;
  logic      addr_hit;
  logic      data_hit;

  // Data wins unless the guard says inst has waited long enough.
  function automatic owner_e pick_owner(input logic i_req, input logic d_req,
                                        input logic hit);
    if (d_req && !(hit && i_req)) return OWN_DATA;
    return OWN_INST;
  endfunction

  assign grant = (state_q == IDLE) && (inst_req || data_req);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    pay_d   = pay_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          owner_d = pick_owner(inst_req, data_req, starve_hit);
          if (owner_d == OWN_DATA) begin
            pay_d.wr    = data_wr;
            pay_d.addr  = data_addr;
            pay_d.wstrb = data_wstrb;
            pay_d.wdata = data_wdata;
          end else begin
            pay_d.wr    = OP_READ;
            pay_d.addr  = inst_addr;
            pay_d.wstrb = 4'h0;
            pay_d.wdata = 32'h0;
          end
          state_d = REQ;
        end
      end
      REQ:     if (m_addr_ok) state_d = RESP;
      RESP:    if (m_data_ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_p) begin
      state_q <= IDLE;
      owner_q <= OWN_INST;
      pay_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      pay_q   <= pay_d;
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve_q, starve_d;

  assign starve_hit = (starve_q == CW'(STARVE_LIMIT));

  // Counts data grants that bypassed a waiting inst; saturates at the limit.
  always_comb begin
    starve_d = starve_q;
    if (grant) begin
      if (owner_d == OWN_DATA && inst_req) begin
        if (!starve_hit) starve_d = starve_q + 1'b1;
      end else begin
        starve_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_p) starve_q <= '0;
    else       starve_q <= starve_d;
  end
`else
  assign starve_hit = 1'b0;
`endif

  assign addr_hit = (state_q == REQ) && m_addr_ok;
  assign data_hit = (state_q == RESP) && m_data_ok;

  assign inst_addr_ok = addr_hit && (owner_q == OWN_INST);
  assign data_addr_ok = addr_hit && (owner_q == OWN_DATA);
  assign inst_data_ok = data_hit && (owner_q == OWN_INST);
  assign data_data_ok = data_hit && (owner_q == OWN_DATA);
  assign inst_rdata   = m_rdata;
  assign data_rdata   = m_rdata;

  assign m_req     = (state_q == REQ);
  assign m_wr      = pay_q.wr;
  assign m_addr    = pay_q.addr;
  assign m_wstrb   = pay_q.wstrb;
  assign m_wdata   = pay_q.wdata;
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: requester drivers and a slave model feed a
// scoreboard of expected master issues and requester responses.
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_p = 1'b1;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0;
  logic        data_wr = 1'b0;
  logic [31:0] data_addr = '0;
  logic [3:0]  data_wstrb = '0;
  logic [31:0] data_wdata = '0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        m_req, m_wr;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_addr_ok = 1'b0;
  logic        m_data_ok = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        busy;
  state_e      state_dbg;

  sram_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_p(rst_p),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_wstrb(m_wstrb), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void check(string name, logic [70:0] act, logic [70:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endfunction

  // ---------------- scoreboard queues ----------------
  // issue entry: {data_addr_ok, inst_addr_ok, wr, addr, wstrb, wdata}
  // resp entry : {data_data_ok, inst_data_ok, rdata}
  logic [70:0] iss_q[$];
  logic [33:0] resp_q[$];
  logic [31:0] rd_q[$];

  task automatic expect_txn(input bit is_data, input logic wr, input logic [31:0] a,
                            input logic [3:0] s, input logic [31:0] d, input logic [31:0] rd);
    iss_q.push_back({is_data, !is_data, wr, a, s, d});
    resp_q.push_back({is_data, !is_data, rd});
    rd_q.push_back(rd);
  endtask

  // ---------------- slave model ----------------
  int   addr_delay = 0;
  int   data_delay = 1;
  logic inject_dok = 1'b0;
  int   sl_phase = 0;
  int   sl_cnt = 0;

  always begin
    @(posedge clk);
    #2;
    m_addr_ok = 1'b0;
    m_data_ok = 1'b0;
    m_rdata   = 32'h0;
    if (rst_p) begin
      sl_phase = 0;
      sl_cnt   = 0;
    end else if (sl_phase == 0) begin
      if (m_req) begin
        if (sl_cnt >= addr_delay) begin
          m_addr_ok = 1'b1;
          sl_phase  = 1;
          sl_cnt    = 0;
        end else sl_cnt++;
      end
    end else begin
      if (sl_cnt >= data_delay) begin
        m_data_ok = 1'b1;
        m_rdata   = (rd_q.size() != 0) ? rd_q.pop_front() : 32'h0;
        sl_phase  = 0;
        sl_cnt    = 0;
      end else sl_cnt++;
    end
    if (inject_dok) begin
      m_data_ok = 1'b1;
      m_rdata   = 32'h5A5A5A5A;
    end
  end

  // ---------------- monitor ----------------
  int          dao_cnt = 0;
  int          ddo_cnt = 0;
  logic        prev_req = 1'b0;
  logic        prev_acc = 1'b0;
  logic [68:0] prev_pay = '0;
  logic [70:0] mon_exp;
  logic [33:0] mon_rexp;

  always @(negedge clk) begin
    if (rst_p) begin
      prev_req = 1'b0;
      prev_acc = 1'b0;
    end else begin
      if (data_addr_ok) dao_cnt++;
      if (data_data_ok) ddo_cnt++;
      if (m_req && prev_req && !prev_acc)
        check("payload_stable", {2'b00, m_wr, m_addr, m_wstrb, m_wdata}, {2'b00, prev_pay});
      if (m_req && m_addr_ok) begin
        mon_exp = (iss_q.size() != 0) ? iss_q.pop_front() : 71'h0;
        check("issue", {data_addr_ok, inst_addr_ok, m_wr, m_addr, m_wstrb, m_wdata}, mon_exp);
      end else if (inst_addr_ok || data_addr_ok) begin
        check("addr_ok_leak", {69'h0, data_addr_ok, inst_addr_ok}, 71'h0);
      end
      if (inst_data_ok || data_data_ok) begin
        mon_rexp = (resp_q.size() != 0) ? resp_q.pop_front() : 34'h0;
        check("response", {37'h0, data_data_ok, inst_data_ok,
                           (data_data_ok ? data_rdata : inst_rdata)}, {37'h0, mon_rexp});
      end
      prev_req = m_req;
      prev_acc = m_req && m_addr_ok;
      prev_pay = {m_wr, m_addr, m_wstrb, m_wdata};
    end
  end

  // ---------------- requester driver ----------------
  task automatic drive_req(input bit is_data, input bit drop_early, input logic wr,
                           input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                           output int a_rel, output int d_rel);
    int c0;
    bit held;
    @(posedge clk);
    #1;
    c0 = cyc;
    a_rel = -1;
    d_rel = -1;
    held = 1'b1;
    if (is_data) begin
      data_req = 1'b1; data_wr = wr; data_addr = a; data_wstrb = s; data_wdata = d;
    end else begin
      inst_req = 1'b1; inst_addr = a;
    end
    for (int i = 0; i < 100 && d_rel < 0; i++) begin
      @(negedge clk);
      if ((is_data ? data_addr_ok : inst_addr_ok) && a_rel < 0) a_rel = cyc - c0;
      if (is_data ? data_data_ok : inst_data_ok) d_rel = cyc - c0;
      @(posedge clk);
      #1;
      if (held && (drop_early || a_rel >= 0)) begin
        if (is_data) data_req = 1'b0; else inst_req = 1'b0;
        held = 1'b0;
      end
    end
    if (is_data) data_req = 1'b0; else inst_req = 1'b0;
    if (d_rel < 0) check("req_timeout", 71'd0, 71'd1);
  endtask

  // ---------------- directed sequence ----------------
  int ia, id, da, dd, n, dao0, ddo0;
  bit is_d;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_p = 1'b0;
    @(negedge clk);
    check("reset_master", {2'b00, m_req, m_wr, m_addr, m_wstrb, m_wdata}, 71'h0);
    check("reset_oks", {67'h0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 71'h0);
    check("reset_busy_state", {68'h0, busy, state_dbg}, {68'h0, 1'b0, IDLE});

    // single inst read: addr_ok at cycle 1, data_ok at cycle 3
    addr_delay = 0; data_delay = 1;
    expect_txn(1'b0, 1'b0, 32'hBFC00000, 4'h0, 32'h0, 32'h3C080001);
    drive_req(1'b0, 1'b0, 1'b0, 32'hBFC00000, 4'h0, 32'h0, ia, id);
    check("inst_lat", {7'h0, 32'(ia), 32'(id)}, {7'h0, 32'd1, 32'd3});

    // simultaneous: data write first, inst read after one IDLE cycle
    data_delay = 0;
    expect_txn(1'b1, 1'b1, 32'h80001000, 4'hF, 32'hDEADBEEF, 32'h0);
    expect_txn(1'b0, 1'b0, 32'hBFC00004, 4'h0, 32'h0, 32'h24020001);
    fork
      drive_req(1'b1, 1'b0, 1'b1, 32'h80001000, 4'hF, 32'hDEADBEEF, da, dd);
      drive_req(1'b0, 1'b0, 1'b0, 32'hBFC00004, 4'h0, 32'h0, ia, id);
    join
    check("simul_data_lat", {7'h0, 32'(da), 32'(dd)}, {7'h0, 32'd1, 32'd2});
    check("simul_inst_lat", {7'h0, 32'(ia), 32'(id)}, {7'h0, 32'd4, 32'd5});

    // slave backpressure: five cycles without addr_ok
    addr_delay = 5; data_delay = 0;
    expect_txn(1'b1, 1'b1, 32'h80002000, 4'h3, 32'h12345678, 32'h0);
    drive_req(1'b1, 1'b0, 1'b1, 32'h80002000, 4'h3, 32'h12345678, da, dd);
    check("bp_lat", {7'h0, 32'(da), 32'(dd)}, {7'h0, 32'd6, 32'd7});

    // data requester drops req while the arbiter is in REQ
    addr_delay = 2; data_delay = 1;
    dao0 = dao_cnt; ddo0 = ddo_cnt;
    expect_txn(1'b1, 1'b0, 32'h80003000, 4'h0, 32'h0, 32'hCAFEF00D);
    drive_req(1'b1, 1'b1, 1'b0, 32'h80003000, 4'h0, 32'h0, da, dd);
    repeat (3) @(negedge clk);
    check("drop_lat", {7'h0, 32'(da), 32'(dd)}, {7'h0, 32'd3, 32'd5});
    check("drop_pulses", {7'h0, 32'(dao_cnt - dao0), 32'(ddo_cnt - ddo0)}, {7'h0, 32'd1, 32'd1});

    // both requesters held high for ten grants
    addr_delay = 0; data_delay = 0;
    for (int k = 0; k < 10; k++) begin
`ifdef ARB_STARVE_GUARD_EN
      is_d = !(k == 4 || k == 9);
`else
      is_d = 1'b1;
`endif
      expect_txn(is_d, 1'b0, is_d ? 32'h00000100 : 32'h00000200, 4'h0, 32'h0, 32'h1000 + k);
    end
    @(posedge clk);
    #1;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h100; data_wstrb = 4'h0; data_wdata = 32'h0;
    inst_req = 1'b1; inst_addr = 32'h200;
    n = 0;
    for (int i = 0; i < 400 && n < 10; i++) begin
      @(negedge clk);
      if (inst_addr_ok || data_addr_ok) n++;
    end
    @(posedge clk);
    #1;
    data_req = 1'b0; inst_req = 1'b0;
    for (int i = 0; i < 50 && resp_q.size() != 0; i++) @(negedge clk);
    check("starve_grants", {39'h0, 32'(n)}, {39'h0, 32'd10});

    // reset while in RESP, then a stray m_data_ok
    addr_delay = 0; data_delay = 20;
    iss_q.push_back({1'b1, 1'b0, 1'b0, 32'h80004000, 4'h0, 32'h0});
    @(posedge clk);
    #1;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h80004000; data_wstrb = 4'h0; data_wdata = 32'h0;
    n = 0;
    for (int i = 0; i < 20 && n == 0; i++) begin
      @(negedge clk);
      if (data_addr_ok) n = 1;
    end
    @(posedge clk);
    #1 data_req = 1'b0;
    @(negedge clk);
    check("pre_reset_resp", {68'h0, busy, state_dbg}, {68'h0, 1'b1, RESP});
    @(posedge clk);
    #1 rst_p = 1'b1;
    @(posedge clk);
    #1 rst_p = 1'b0;
    inject_dok = 1'b1;
    @(negedge clk);
    check("post_reset_dok", {67'h0, inst_data_ok, data_data_ok, busy, m_req}, 71'h0);
    check("post_reset_state", {69'h0, state_dbg}, {69'h0, IDLE});
    @(posedge clk);
    #1 inject_dok = 1'b0;
    repeat (3) @(negedge clk);
    check("post_reset_idle", {69'h0, busy, m_req}, 71'h0);

    // recovery: fresh inst read after the abandoned transaction
    data_delay = 1;
    expect_txn(1'b0, 1'b0, 32'hBFC00010, 4'h0, 32'h0, 32'h0000BEEF);
    drive_req(1'b0, 1'b0, 1'b0, 32'hBFC00010, 4'h0, 32'h0, ia, id);
    check("recover_lat", {7'h0, 32'(ia), 32'(id)}, {7'h0, 32'd1, 32'd3});

    repeat (2) @(negedge clk);
    check("queues_drained", {39'h0, 16'(iss_q.size()), 16'(resp_q.size())}, 71'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
